frame_timer_bank: RTL and testbench

//  Multi-channel game-timing engine. Divides clk down to a shared frame tick
//  (TICK_HZ), and on top of it runs NUM_CH independent frame counters with

---
 rtl/frame_timer_pkg.sv | 21 ++
 rtl/frame_timer_bank_if.sv | 25 ++
 rtl/frame_timer_channel.sv | 93 +++++++++
 rtl/frame_timer_bank.sv | 75 +++++++
 tb/tb_frame_timer_bank.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_timer_pkg.sv
// Shared types and elaboration helpers for the frame timer bank.
// Holds the channel state encoding and the divider sizing functions.
package frame_timer_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_DONE = 2'd2
   } ch_state_e;

   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Width of a counter that spans 0..div-1; never narrower than one bit.
   function automatic int unsigned calc_cnt_w(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/frame_timer_bank_if.sv
// Control and status bundle of the frame timer bank.
// The bank side takes the slave modport; the controller side takes master.
interface frame_timer_bank_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned PW     = 8
);
   logic [NUM_CH-1:0]    ch_enable;
   logic [NUM_CH-1:0]    ch_oneshot;
   logic [NUM_CH-1:0]    ch_clear;
   logic [NUM_CH*PW-1:0] ch_period;
   logic                 frame_tick;
   logic [NUM_CH-1:0]    ch_tick;
   logic [NUM_CH-1:0]    ch_done;
   logic [NUM_CH-1:0]    ch_busy;

   modport master (
      output ch_enable, ch_oneshot, ch_clear, ch_period,
      input  frame_tick, ch_tick, ch_done, ch_busy
   );

   modport slave (
      input  ch_enable, ch_oneshot, ch_clear, ch_period,
      output frame_tick, ch_tick, ch_done, ch_busy
   );
endinterface

// File: rtl/frame_timer_channel.sv
// One frame-counting channel: IDLE/RUN/DONE with periodic or one-shot expiry.
// tick_o fires one cycle after the frame tick that completes the period; all outputs are registered.
module frame_timer_channel
   import frame_timer_pkg::*;
#(
   parameter int unsigned PW = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          en_i,
   input  logic          oneshot_i,
   input  logic          clear_i,
   input  logic [PW-1:0] period_i,
   input  logic          frame_tick_i,
   output logic          tick_o,
   output logic          done_o,
   output logic          busy_o
);

   ch_state_e     state_q;
   logic [PW-1:0] fcnt_q;
   logic [PW-1:0] per_q;
   logic          oneshot_q;
   logic          tick_q;
   logic          done_q;
   logic          busy_q;
   logic [PW-1:0] period_eff;

   // A zero period would never expire; run it as a one-frame period.
   assign period_eff = (period_i == '0) ? PW'(1) : period_i;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= CH_IDLE;
         fcnt_q    <= '0;
         per_q     <= PW'(1);
         oneshot_q <= 1'b0;
         tick_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (!en_i) begin
            state_q <= CH_IDLE;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               CH_IDLE: begin
                  state_q   <= CH_RUN;
                  fcnt_q    <= '0;
                  per_q     <= period_eff;
                  oneshot_q <= oneshot_i;
                  busy_q    <= 1'b1;
               end
               CH_RUN: begin
                  if (clear_i) begin
                     fcnt_q <= '0;
                  end else if (frame_tick_i) begin
                     if (fcnt_q == per_q - PW'(1)) begin
                        tick_q <= 1'b1;
                        fcnt_q <= '0;
                        per_q  <= period_eff;
                        if (oneshot_q) begin
                           state_q <= CH_DONE;
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                        end
                     end else begin
                        fcnt_q <= fcnt_q + PW'(1);
                     end
                  end
               end
               CH_DONE: begin
                  done_q <= 1'b1;
               end
               default: begin
                  state_q <= CH_IDLE;
                  fcnt_q  <= '0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tick_o = tick_q;
   assign done_o = done_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/frame_timer_bank.sv
// Shared clk/DIV frame-tick divider feeding NUM_CH independent frame counters.
// frame_tick is registered and runs only while some channel is enabled.
module frame_timer_bank
   import frame_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 60,
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned PW      = 8
) (
   input  logic               clk,
   input  logic               resetn,
   frame_timer_bank_if.slave  bus
);

   localparam int unsigned   DIV      = calc_div(CLK_HZ, TICK_HZ);
   localparam int unsigned   CW       = calc_cnt_w(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0]     div_cnt_q;
   logic [CW-1:0]     div_cnt_d;
   logic              frame_tick_q;
   logic              frame_tick_d;
   logic              any_en;
   logic [NUM_CH-1:0] ch_tick;
   logic [NUM_CH-1:0] ch_done;
   logic [NUM_CH-1:0] ch_busy;

   assign any_en = |bus.ch_enable;

   // The tick is raised on the wrap itself so the period is exactly DIV clocks.
   always_comb begin
      div_cnt_d    = '0;
      frame_tick_d = 1'b0;
      if (any_en) begin
         if (div_cnt_q == CNT_LAST) begin
            div_cnt_d    = '0;
            frame_tick_d = 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt_q    <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      frame_timer_channel #(.PW(PW)) u_ch (
         .clk          (clk),
         .resetn       (resetn),
         .en_i         (bus.ch_enable[g]),
         .oneshot_i    (bus.ch_oneshot[g]),
         .clear_i      (bus.ch_clear[g]),
         .period_i     (bus.ch_period[g*PW +: PW]),
         .frame_tick_i (frame_tick_q),
         .tick_o       (ch_tick[g]),
         .done_o       (ch_done[g]),
         .busy_o       (ch_busy[g])
      );
   end

   assign bus.frame_tick = frame_tick_q;
   assign bus.ch_tick    = ch_tick;
   assign bus.ch_done    = ch_done;
   assign bus.ch_busy    = ch_busy;

endmodule

// File: tb/tb_frame_timer_bank.sv
// Bench for frame_timer_bank with DIV=10: directed timing scenarios plus random traffic,
// scored cycle by cycle against a countdown reference model through an expectation queue.
module tb_frame_timer_bank;

   localparam int NUM_CH = 4;
   localparam int PW     = 8;
   localparam int DIV    = 10;

   typedef struct packed {
      logic              ft;
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] done;
      logic [NUM_CH-1:0] busy;
   } exp_t;

   logic clk;
   logic resetn;

   frame_timer_bank_if #(.NUM_CH(NUM_CH), .PW(PW)) bus ();

   frame_timer_bank #(
      .CLK_HZ (100),
      .TICK_HZ(10),
      .NUM_CH (NUM_CH),
      .PW     (PW)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: each running channel counts down the frame ticks left in its period.
   exp_t sb[$];
   bit   m_run [NUM_CH];
   bit   m_fin [NUM_CH];
   bit   m_os  [NUM_CH];
   int   m_left[NUM_CH];
   int   m_per [NUM_CH];
   int   m_elapsed;
   bit   m_ft;
   exp_t m_e;
   bit   m_seen;
   int   m_p;

   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_run[i] = 0; m_fin[i] = 0; m_os[i] = 0; m_left[i] = 0; m_per[i] = 0;
         end
         m_elapsed = 0;
         m_ft      = 0;
      end else begin
         m_seen = m_ft;
         m_e    = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_p = int'(bus.ch_period[i*PW +: PW]);
            if (m_p == 0) m_p = 1;
            if (!bus.ch_enable[i]) begin
               m_run[i] = 0;
               m_fin[i] = 0;
            end else if (!m_run[i] && !m_fin[i]) begin
               m_run[i]  = 1;
               m_per[i]  = m_p;
               m_left[i] = m_p;
               m_os[i]   = bus.ch_oneshot[i];
            end else if (m_run[i]) begin
               if (bus.ch_clear[i]) begin
                  m_left[i] = m_per[i];
               end else if (m_seen) begin
                  m_left[i]--;
                  if (m_left[i] == 0) begin
                     m_e.tick[i] = 1'b1;
                     m_per[i]    = m_p;
                     m_left[i]   = m_p;
                     if (m_os[i]) begin
                        m_run[i] = 0;
                        m_fin[i] = 1;
                     end
                  end
               end
            end
            m_e.done[i] = m_fin[i];
            m_e.busy[i] = m_run[i];
         end
         if (|bus.ch_enable) begin
            m_elapsed++;
            m_ft = (m_elapsed % DIV) == 0;
         end else begin
            m_elapsed = 0;
            m_ft      = 0;
         end
         m_e.ft = m_ft;
         sb.push_back(m_e);
      end
   end

   // Monitor: compares the DUT against the oldest expectation each cycle.
   exp_t mon_e;
   always @(negedge clk) begin
      if (!resetn) begin
         sb.delete();
         mon_e = '0;
      end else if (sb.size() > 0) begin
         mon_e = sb.pop_front();
      end else begin
         mon_e = '0;
      end
      chk("frame_tick", int'(bus.frame_tick), int'(mon_e.ft));
      chk("ch_tick",    int'(bus.ch_tick),    int'(mon_e.tick));
      chk("ch_done",    int'(bus.ch_done),    int'(mon_e.done));
      chk("ch_busy",    int'(bus.ch_busy),    int'(mon_e.busy));
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_period(input int ch, input int val);
      bus.ch_period[ch*PW +: PW] = PW'(val);
   endtask

   // Clocks from the edge that samples the stimulus to the first visible ch_tick.
   task automatic wait_tick(input int ch, input int exp_clks, input string name);
      int  n;
      bit  seen;
      n    = 0;
      seen = 0;
      @(posedge clk);
      while (n <= exp_clks + 3*DIV) begin
         @(negedge clk);
         if (bus.ch_tick[ch]) begin
            seen = 1;
            break;
         end
         n++;
      end
      chk(name, seen ? n : -1, exp_clks);
      cyc();
   endtask

   int cnt[NUM_CH];

   initial begin
      resetn         = 1'b0;
      bus.ch_enable  = '0;
      bus.ch_oneshot = '0;
      bus.ch_clear   = '0;
      bus.ch_period  = '0;
      cyc(3);
      resetn = 1'b1;
      cyc(2);

      // Periodic, period 8: first tick at 80, then every 80.
      set_period(0, 8);
      bus.ch_enable = 4'b0001;
      wait_tick(0, 80, "ch0_first_tick");
      cyc(170);
      bus.ch_enable = '0;
      cyc(3);

      // One-shot, period 3: single tick, done held, cleared by disable, re-armed.
      set_period(1, 3);
      bus.ch_oneshot[1] = 1'b1;
      bus.ch_enable     = 4'b0010;
      wait_tick(1, 30, "ch1_oneshot_tick");
      cyc(40);
      bus.ch_enable = '0;
      cyc(3);
      bus.ch_enable = 4'b0010;
      wait_tick(1, 30, "ch1_reenable_tick");
      cyc(5);
      bus.ch_enable     = '0;
      bus.ch_oneshot[1] = 1'b0;
      cyc(3);

      // Period 0 behaves as 1; period change mid-period lands at the next wrap.
      set_period(2, 0);
      bus.ch_enable = 4'b0100;
      wait_tick(2, 10, "ch2_period0_tick");
      cyc(30);
      set_period(2, 4);
      cyc(55);
      set_period(2, 2);
      cyc(120);
      bus.ch_enable = '0;
      cyc(3);

      // Disable in the expiry cycle suppresses the tick.
      set_period(0, 2);
      bus.ch_enable = 4'b0001;
      cyc(20);
      bus.ch_enable = '0;
      cyc(5);

      // Clear partway through a period of 8.
      set_period(0, 8);
      bus.ch_enable = 4'b0001;
      cyc(55);
      bus.ch_clear[0] = 1'b1;
      cyc();
      bus.ch_clear[0] = 1'b0;
      cyc(100);
      bus.ch_enable = '0;
      cyc(3);

      // Four channels, periods 1..4, over 120 clocks.
      for (int i = 0; i < NUM_CH; i++) begin
         set_period(i, i + 1);
         cnt[i] = 0;
      end
      bus.ch_enable = 4'b1111;
      @(posedge clk);
      repeat (121) begin
         @(negedge clk);
         for (int i = 0; i < NUM_CH; i++) cnt[i] += int'(bus.ch_tick[i]);
      end
      chk("four_ch_count0", cnt[0], 12);
      chk("four_ch_count1", cnt[1], 6);
      chk("four_ch_count2", cnt[2], 4);
      chk("four_ch_count3", cnt[3], 3);
      cyc();
      bus.ch_enable = '0;
      cyc(30);

      // Asynchronous reset mid-run, off the clock edge, with enable held.
      set_period(0, 3);
      bus.ch_enable = 4'b0001;
      cyc(15);
      #1 resetn = 1'b0;
      #1;
      chk("rst_frame_tick", int'(bus.frame_tick), 0);
      chk("rst_ch_tick",    int'(bus.ch_tick),    0);
      chk("rst_ch_done",    int'(bus.ch_done),    0);
      chk("rst_ch_busy",    int'(bus.ch_busy),    0);
      cyc(2);
      resetn = 1'b1;
      wait_tick(0, 30, "post_reset_tick");
      bus.ch_enable = '0;
      cyc(3);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(15) == 0) bus.ch_enable[i] = ~bus.ch_enable[i];
            if ($urandom_range(7) == 0)  bus.ch_oneshot[i] = 1'($urandom_range(1));
            if ($urandom_range(30) == 0) set_period(i, int'($urandom_range(4)));
            bus.ch_clear[i] = ($urandom_range(40) == 0);
         end
         cyc();
      end
      bus.ch_clear  = '0;
      bus.ch_enable = '0;
      cyc(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
